// File: rtl/chunked_seq_adder_if.sv
// rtl/chunked_seq_adder_if.sv - operand and result handshake bundle for chunked_seq_adder
interface chunked_seq_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/chunked_seq_adder.sv
// rtl/chunked_seq_adder.sv - multi-cycle add/sub processing CHUNK bits per clock, LS chunk first
module chunked_seq_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic               clk,
    input  logic               rst,
    chunked_seq_adder_if.slave bus
);
    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (CHUNK == 0) begin : g_bad_chunk
            $error("chunked_seq_adder: CHUNK must be non-zero");
        end else if (WIDTH % CHUNK != 0) begin : g_bad_width
            $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic             out_valid_r;

    logic [BW-1:0]    base;
    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] acc_next;

    // b_r already holds ~b for subtraction, so the datapath is always an add
    always_comb begin
        base      = BW'(int'(idx) * CHUNK);
        chunk_sum = {1'b0, a_r[base +: CHUNK]} + {1'b0, b_r[base +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry};
        acc_next  = acc;
        acc_next[base +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry       <= 1'b0;
            a_r         <= '0;
            b_r         <= '0;
            acc         <= '0;
            sum_r       <= '0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r   <= bus.a;
                        b_r   <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub ? 1'b1 : bus.cin;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= chunk_sum[CHUNK];
                    idx   <= idx + 1'b1;
                    // final chunk: publish the complete result together with its flags
                    if (idx == LAST_IDX) begin
                        sum_r       <= acc_next;
                        cout_r      <= chunk_sum[CHUNK];
                        ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1])
                                    && (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE) && !rst;
    assign bus.out_valid = out_valid_r;
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_chunked_seq_adder.sv
// tb/tb_chunked_seq_adder.sv - scoreboard bench for chunked_seq_adder (16/4 directed, 16/16 and 8/1 random)
`timescale 1ns/1ps
module tb_chunked_seq_adder;
    typedef struct packed {
        logic        cout;
        logic        ovf;
        logic [31:0] sum;
        logic [31:0] acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    chunked_seq_adder_if #(.WIDTH(16)) m ();
    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut (.clk(clk), .rst(rst), .bus(m));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // signed-range reference, independent of the carry-based flag formula
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint half, mask, ua, ub, r, sa, sb, sr;
        half = longint'(1) << (w - 1);
        mask = (half << 1) - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (sub) begin
            r      = ua - ub;
            e.cout = (ua >= ub);
        end else begin
            r      = ua + ub + longint'(cin);
            e.cout = ((r >> w) & 1) != 0;
        end
        e.sum = 32'(r & mask);
        sa    = (ua >= half) ? ua - 2 * half : ua;
        sb    = (ub >= half) ? ub - 2 * half : ub;
        sr    = sub ? sa - sb : sa + sb + longint'(cin);
        e.ovf = (sr >= half) || (sr < -half);
        e.acc = 32'd0;
        return e;
    endfunction

    function automatic exp_t ex(input logic [15:0] s, input logic c, input logic o);
        return '{cout: c, ovf: o, sum: 32'(s), acc: 32'd0};
    endfunction

    always @(negedge clk) begin
        if (!rst && m.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 32'(m.out_valid), 32'd0);
            end else begin
                if (!seen) begin
                    check("latency", cyc, q[0].acc + 32'd4);
                    seen = 1'b1;
                end
                check("sum", 32'(m.sum), q[0].sum);
                check("cout", 32'(m.cout), 32'(q[0].cout));
                check("ovf", 32'(m.ovf), 32'(q[0].ovf));
                if (m.out_ready) begin
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input exp_t e);
        int n = 0;
        m.a = a; m.b = b; m.cin = cin; m.sub = sub; m.in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!m.in_ready && n < 100);
        check("accept", 32'(m.in_ready), 32'd1);
        e.acc = cyc + 1;
        q.push_back(e);
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        m.a = 16'($urandom); m.b = 16'($urandom);
        m.cin = 1'($urandom); m.sub = 1'($urandom);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", q.size(), 32'd0);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_rnd
        localparam int W = (g == 0) ? 16 : 8;
        localparam int C = (g == 0) ? 16 : 1;
        localparam int N = W / C;
        logic r_rst;
        logic r_seen    = 1'b0;
        logic done_flag = 1'b0;
        exp_t rq[$];

        chunked_seq_adder_if #(.WIDTH(W)) rb ();
        chunked_seq_adder #(.WIDTH(W), .CHUNK(C)) u_dut (.clk(clk), .rst(r_rst), .bus(rb));

        always @(posedge clk) begin
            #1;
            rb.out_ready = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin
            if (!r_rst && rb.out_valid) begin
                if (rq.size() == 0) begin
                    check($sformatf("rnd%0d_spurious", g), 32'(rb.out_valid), 32'd0);
                end else begin
                    if (!r_seen) begin
                        check($sformatf("rnd%0d_latency", g), cyc, rq[0].acc + 32'(N));
                        r_seen = 1'b1;
                    end
                    check($sformatf("rnd%0d_sum", g), 32'(rb.sum), rq[0].sum);
                    check($sformatf("rnd%0d_cout", g), 32'(rb.cout), 32'(rq[0].cout));
                    check($sformatf("rnd%0d_ovf", g), 32'(rb.ovf), 32'(rq[0].ovf));
                    if (rb.out_ready) begin
                        void'(rq.pop_front());
                        r_seen = 1'b0;
                    end
                end
            end
        end

        initial begin
            logic [W-1:0] ra;
            logic [W-1:0] rbv;
            logic         rc;
            logic         rs;
            exp_t         e;
            int           n;
            r_rst = 1'b1;
            rb.in_valid = 1'b0; rb.a = '0; rb.b = '0; rb.cin = 1'b0; rb.sub = 1'b0;
            rb.out_ready = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            r_rst = 1'b0;
            for (int i = 0; i < 1000; i++) begin
                ra  = W'($urandom);
                rbv = W'($urandom);
                rc  = 1'($urandom);
                rs  = 1'($urandom);
                case ($urandom_range(0, 7))
                    0: rbv = ~ra;
                    1: ra  = {1'b0, {(W-1){1'b1}}};
                    2: ra  = {1'b1, {(W-1){1'b0}}};
                    default: ;
                endcase
                rb.a = ra; rb.b = rbv; rb.cin = rc; rb.sub = rs; rb.in_valid = 1'b1;
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!rb.in_ready && n < 100);
                check($sformatf("rnd%0d_accept", g), 32'(rb.in_ready), 32'd1);
                e     = model(W, 32'(ra), 32'(rbv), rc, rs);
                e.acc = cyc + 1;
                rq.push_back(e);
                @(posedge clk); #1;
                rb.in_valid = ($urandom_range(0, 1) == 0);
                rb.a = W'($urandom); rb.b = W'($urandom);
            end
            rb.in_valid = 1'b0;
            n = 0;
            while (rq.size() != 0 && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            check($sformatf("rnd%0d_drain", g), rq.size(), 32'd0);
            done_flag = 1'b1;
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        m.in_valid = 1'b0; m.a = '0; m.b = '0; m.cin = 1'b0; m.sub = 1'b0;
        m.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(m.in_ready), 32'd0);
        check("rst_out_valid", 32'(m.out_valid), 32'd0);
        check("rst_sum", 32'(m.sum), 32'd0);
        check("rst_cout", 32'(m.cout), 32'd0);
        check("rst_ovf", 32'(m.ovf), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 32'(m.in_ready), 32'd1);

        send(16'h00FF, 16'h0001, 1'b0, 1'b0, ex(16'h0100, 1'b0, 1'b0));
        wait_drain();
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, ex(16'h0000, 1'b1, 1'b0));
        send(16'h7FFF, 16'h0000, 1'b1, 1'b0, ex(16'h8000, 1'b0, 1'b1));
        send(16'h8000, 16'h0001, 1'b0, 1'b1, ex(16'h7FFF, 1'b1, 1'b1));
        send(16'h0001, 16'h0002, 1'b0, 1'b1, ex(16'hFFFF, 1'b0, 1'b0));
        send(16'h0005, 16'h0003, 1'b1, 1'b1, ex(16'h0002, 1'b1, 1'b0));
        wait_drain();

        // backpressure with in_valid noise during RUN and DONE
        m.out_ready = 1'b0;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, ex(16'h5555, 1'b0, 1'b0));
        @(posedge clk); #1;
        m.in_valid = 1'b1; m.a = 16'hAAAA; m.b = 16'h5555;
        check("in_ready_run", 32'(m.in_ready), 32'd0);
        @(posedge clk); #1;
        m.in_valid = 1'b0;
        n = 0;
        while (!m.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid", 32'(m.out_valid), 32'd1);
        repeat (6) begin
            m.in_valid = 1'b1;
            check("in_ready_done", 32'(m.in_ready), 32'd0);
            @(posedge clk); #1;
        end
        m.in_valid  = 1'b0;
        m.out_ready = 1'b1;
        @(posedge clk); #1;
        check("valid_drop", 32'(m.out_valid), 32'd0);
        check("in_ready_back", 32'(m.in_ready), 32'd1);
        check("bp_popped", q.size(), 32'd0);

        // reset two cycles into RUN abandons the operation
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, ex(16'hFFFE, 1'b1, 1'b0));
        @(posedge clk); #1;
        rst = 1'b1;
        q.delete();
        seen = 1'b0;
        #1;
        check("in_ready_in_rst", 32'(m.in_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_out_valid", 32'(m.out_valid), 32'd0);
        check("midrst_sum", 32'(m.sum), 32'd0);
        check("midrst_cout", 32'(m.cout), 32'd0);
        check("midrst_ovf", 32'(m.ovf), 32'd0);
        check("midrst_in_ready", 32'(m.in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) begin
            check("no_valid_after_rst", 32'(m.out_valid), 32'd0);
            @(posedge clk); #1;
        end
        send(16'h0F0F, 16'h00F1, 1'b1, 1'b0, ex(16'h1001, 1'b0, 1'b0));
        wait_drain();

        n = 0;
        while (!(g_rnd[0].done_flag && g_rnd[1].done_flag) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        check("rnd_done", {30'd0, g_rnd[1].done_flag, g_rnd[0].done_flag}, 32'd3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
